// File: rtl/sobel_frame_sched.sv
// ----------------------------------------------------------------------------
// sobel_frame_sched
//   Frame scheduler in front of a Sobel/move engine. It captures one frame of
//   IMAGE_WIDTH*IMAGE_HEIGHT pixels from a valid/ready stream into BRAM0,
//   launches the engine once it reports idle, waits for its done pulse, and
//   reports completion.
//
//   Optional build macro: SOBEL_SCHED_TIMEOUT_EN
//     Defined   -> a watchdog abandons PROC after TIMEOUT_CYCLES cycles without
//                  i_eng_done and raises o_err[1].
//     Undefined -> no watchdog, PROC waits indefinitely, o_err[1] is 0.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_start           arm one frame capture (honoured in IDLE only)
//   i_sobel_mode      engine mode, sampled together with i_start
//   s_valid/s_data/s_last/s_ready   pixel stream (accepted in FILL only)
//   b0_ce0/b0_we0/b0_addr0/b0_d0    BRAM0 write port, driven combinationally
//   o_en              one-cycle engine launch pulse
//   o_run/o_num_cnt   engine mode and frame size, valid while busy
//   i_eng_idle        engine idle
//   i_eng_done        engine done pulse (honoured in PROC only)
//   o_busy            scheduler not in IDLE
//   o_frame_done      one-cycle completion pulse
//   o_frame_cnt       completed frame count (wraps)
//   o_err             sticky errors: [0] frame length, [1] engine timeout
// ----------------------------------------------------------------------------
module sobel_frame_sched #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int IMAGE_WIDTH    = 5,
    parameter int IMAGE_HEIGHT   = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_sobel_mode,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  b0_ce0,
    output logic                  b0_we0,
    output logic [ADDR_WIDTH-1:0] b0_addr0,
    output logic [DATA_WIDTH-1:0] b0_d0,
    output logic                  o_en,
    output logic                  o_run,
    output logic [ADDR_WIDTH-1:0] o_num_cnt,
    input  logic                  i_eng_idle,
    input  logic                  i_eng_done,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic [15:0]           o_frame_cnt,
    output logic [1:0]            o_err
);

    localparam int FRAME_N = IMAGE_WIDTH * IMAGE_HEIGHT;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FILL   = 3'd1;
    localparam logic [2:0] LAUNCH = 3'd2;
    localparam logic [2:0] PROC   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]            state;
    logic [2:0]            state_nx;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] pix_cnt;
    logic [15:0]           frame_cnt;
    logic                  err_len;
    logic                  err_to;
    logic                  start_ok;
    logic                  accept;
    logic                  last_slot;
    logic                  to_hit;

    assign start_ok  = (state == IDLE) && i_start;
    assign accept    = (state == FILL) && s_valid;
    assign last_slot = (pix_cnt == ADDR_WIDTH'(FRAME_N - 1));

`ifdef SOBEL_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WD_W-1:0] wd_cnt;

    // wd_cnt holds the number of PROC cycles already elapsed; done wins a tie.
    assign to_hit = (state == PROC) && !i_eng_done &&
                    (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_to <= 1'b0;
        end else begin
            wd_cnt <= (state == PROC) ? wd_cnt + 1'b1 : '0;
            if (start_ok)
                err_to <= 1'b0;
            else if (to_hit)
                err_to <= 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
    assign err_to = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (i_start) state_nx = FILL;
            FILL: begin
                if (accept) begin
                    if (s_last && last_slot)
                        state_nx = LAUNCH;
                    else if (s_last || last_slot)
                        state_nx = IDLE;
                end
            end
            LAUNCH: if (i_eng_idle) state_nx = PROC;
            PROC: begin
                if (i_eng_done)
                    state_nx = DONE;
                else if (to_hit)
                    state_nx = IDLE;
            end
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            pix_cnt   <= '0;
            frame_cnt <= '0;
            err_len   <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                mode_q  <= i_sobel_mode;
                pix_cnt <= '0;
                err_len <= 1'b0;
            end else if (accept) begin
                pix_cnt <= pix_cnt + 1'b1;
                // Early s_last or a missing s_last on the final slot.
                if (s_last != last_slot)
                    err_len <= 1'b1;
            end
            if (state == DONE)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign s_ready      = (state == FILL);
    assign b0_ce0       = accept;
    assign b0_we0       = accept;
    assign b0_addr0     = accept ? pix_cnt : '0;
    assign b0_d0        = accept ? s_data : '0;
    assign o_en         = (state == LAUNCH) && i_eng_idle;
    assign o_busy       = (state != IDLE);
    assign o_run        = o_busy && mode_q;
    assign o_num_cnt    = o_busy ? ADDR_WIDTH'(FRAME_N) : '0;
    assign o_frame_done = (state == DONE);
    assign o_frame_cnt  = frame_cnt;
    assign o_err        = {err_to, err_len};

endmodule

// File: tb/tb_sobel_frame_sched.sv
// ----------------------------------------------------------------------------
// tb_sobel_frame_sched
//   Directed bench for sobel_frame_sched (5x5 frame). Inputs are driven on the
//   falling clock edge and outputs are checked 1 ns later; the DUT acts on the
//   rising edge. The timeout scenario runs only when SOBEL_SCHED_TIMEOUT_EN is
//   defined for the build.
// ----------------------------------------------------------------------------
module tb_sobel_frame_sched;

    localparam int DW = 8;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_sobel_mode = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          b0_ce0;
    logic          b0_we0;
    logic [AW-1:0] b0_addr0;
    logic [DW-1:0] b0_d0;
    logic          o_en;
    logic          o_run;
    logic [AW-1:0] o_num_cnt;
    logic          i_eng_idle = 1'b1;
    logic          i_eng_done = 1'b0;
    logic          o_busy;
    logic          o_frame_done;
    logic [15:0]   o_frame_cnt;
    logic [1:0]    o_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    sobel_frame_sched #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .IMAGE_WIDTH   (5),
        .IMAGE_HEIGHT  (5),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_sobel_mode(i_sobel_mode),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .b0_ce0      (b0_ce0),
        .b0_we0      (b0_we0),
        .b0_addr0    (b0_addr0),
        .b0_d0       (b0_d0),
        .o_en        (o_en),
        .o_run       (o_run),
        .o_num_cnt   (o_num_cnt),
        .i_eng_idle  (i_eng_idle),
        .i_eng_done  (i_eng_done),
        .o_busy      (o_busy),
        .o_frame_done(o_frame_done),
        .o_frame_cnt (o_frame_cnt),
        .o_err       (o_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Arm a capture in IDLE; returns on the falling edge after the start edge.
    task automatic arm(input logic mode);
        @(negedge clk);
        i_start      = 1'b1;
        i_sobel_mode = mode;
        @(negedge clk);
        i_start      = 1'b0;
        i_sobel_mode = 1'b0;
    endtask

    // Stream n pixels (data = 8'h40 + index), s_last on index last_at.
    task automatic feed(input int n, input int last_at, input logic mode);
        for (int p = 0; p < n; p++) begin
            if (p != 0) @(negedge clk);
            s_valid = 1'b1;
            s_data  = DW'(8'h40 + p);
            s_last  = (p == last_at);
            #1;
            check("s_ready", s_ready, 1);
            check("we0", {b0_ce0, b0_we0}, 2'b11);
            check("addr0", b0_addr0, p);
            check("d0", b0_d0, 8'h40 + p);
            check("run", o_run, mode);
            check("num_cnt", o_num_cnt, 25);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        #1;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_ready", s_ready, 0);
        check("rst_en", o_en, 0);
        check("rst_err", o_err, 0);
        check("rst_fcnt", o_frame_cnt, 0);
        check("rst_num", o_num_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // i_eng_done in IDLE is ignored
        i_eng_done = 1'b1;
        @(negedge clk);
        i_eng_done = 1'b0;
        #1;
        check("idle_done_ign", {o_frame_done, o_busy}, 2'b00);

        // Full Sobel frame, engine busy for 10 cycles after the fill
        i_eng_idle = 1'b0;
        arm(1'b1);
        #1;
        check("fill_busy", o_busy, 1);
        feed(25, 24, 1'b1);
        for (int c = 0; c < 10; c++) begin
            check("launch_hold_en", o_en, 0);
            check("launch_busy", {o_busy, s_ready, b0_we0}, 3'b100);
            @(negedge clk);
            #1;
        end
        i_eng_idle = 1'b1;
        #1;
        check("launch_en", o_en, 1);
        check("launch_run", o_run, 1);
        @(negedge clk);
        #1;
        check("proc_en_low", o_en, 0);
        check("proc_num", o_num_cnt, 25);
        // a stray start in PROC must not disturb anything
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        check("proc_start_ign", {o_busy, o_frame_done, s_ready}, 3'b100);
        i_eng_done = 1'b1;
        #1;
        check("proc_no_done_yet", o_frame_done, 0);
        @(negedge clk);
        i_eng_done = 1'b0;
        #1;
        check("done_pulse", o_frame_done, 1);
        check("done_cnt_old", o_frame_cnt, 0);
        check("done_busy", o_busy, 1);
        @(negedge clk);
        #1;
        check("post_done_pulse", o_frame_done, 0);
        check("post_cnt", o_frame_cnt, 1);
        check("post_busy", o_busy, 0);
        check("post_run", o_run, 0);
        check("post_num", o_num_cnt, 0);
        check("post_err", o_err, 0);

        // Early s_last on pixel 10
        arm(1'b0);
        feed(10, 9, 1'b0);
        check("short_err", o_err, 2'b01);
        check("short_state", {o_busy, o_en, s_ready}, 3'b000);
        @(negedge clk);
        #1;
        check("short_sticky", o_err, 2'b01);
        check("short_no_en", o_en, 0);

        // Restart clears the error; 25 pixels without s_last
        arm(1'b0);
        #1;
        check("err_clear", o_err, 2'b00);
        feed(25, 99, 1'b0);
        check("long_err", o_err, 2'b01);
        check("long_idle", o_busy, 0);
        check("long_cnt", o_frame_cnt, 1);

        // Reset during pixel 12 of a fill
        arm(1'b1);
        feed(12, 99, 1'b1);
        s_valid = 1'b1;
        s_data  = 8'hA5;
        #1;
        check("pre_rst_addr", b0_addr0, 12);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_ready", {s_ready, b0_ce0, b0_we0}, 3'b000);
        check("arst_addr", b0_addr0, 0);
        check("arst_d0", b0_d0, 0);
        check("arst_busy", {o_busy, o_run, o_en, o_frame_done}, 4'b0000);
        check("arst_cnt", o_frame_cnt, 0);
        check("arst_err", o_err, 0);
        check("arst_num", o_num_cnt, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("no_restart", {o_busy, o_frame_done}, 2'b00);

`ifdef SOBEL_SCHED_TIMEOUT_EN
        // Watchdog: 16 PROC cycles without i_eng_done
        arm(1'b1);
        feed(25, 24, 1'b1);
        check("to_launch_en", o_en, 1);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            #1;
            check("to_proc_busy", {o_busy, o_frame_done}, 2'b10);
        end
        @(negedge clk);
        #1;
        check("to_idle", {o_busy, o_frame_done}, 2'b00);
        check("to_err", o_err, 2'b10);
        check("to_cnt", o_frame_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/sobel_frame_sched.md
SOBEL_FRAME_SCHED -- requirements
Module: sobel_frame_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, BRAM address width.
REQ-003 SHALL have parameter IMAGE_WIDTH, default 5, pixels per row.
REQ-004 SHALL have parameter IMAGE_HEIGHT, default 5, rows per frame; FRAME_N = IMAGE_WIDTH*IMAGE_HEIGHT.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, engine watchdog limit.
REQ-006 SHALL have one clock and an asynchronous active-low reset, ports clk and rst_n, listed first.
REQ-007 SHALL have ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
i_start  in  1  arm one frame capture
i_sobel_mode  in  1  1 = Sobel, 0 = move; sampled with i_start
s_valid  in  1  pixel valid
s_data  in  DATA_WIDTH  pixel
s_last  in  1  last pixel of frame
s_ready  out  1  pixel accept
b0_ce0  out  1  BRAM0 write-port enable
b0_we0  out  1  BRAM0 write enable
b0_addr0  out  ADDR_WIDTH  BRAM0 write address
b0_d0  out  DATA_WIDTH  BRAM0 write data
o_en  out  1  engine launch pulse
o_run  out  1  engine mode
o_num_cnt  out  ADDR_WIDTH  engine frame size
i_eng_idle  in  1  engine idle
i_eng_done  in  1  engine done pulse
o_busy  out  1  not in IDLE
o_frame_done  out  1  one-cycle completion pulse
o_frame_cnt  out  16  completed frames
o_err  out  2  sticky error: [0] length, [1] timeout

Function
REQ-008 SHALL implement states IDLE, FILL, LAUNCH, PROC, DONE.
REQ-009 IDLE: i_start=1 SHALL latch i_sobel_mode into mode register, clear pixel counter, go FILL; i_start ignored elsewhere.
REQ-010 FILL: s_ready SHALL be 1; each s_valid&s_ready cycle SHALL drive b0_ce0=b0_we0=1, b0_addr0=pixel counter, b0_d0=s_data in the same cycle (combinational), then increment counter.
REQ-011 FILL: accepted pixel with s_last=1 and counter==FRAME_N-1 SHALL go LAUNCH.
REQ-012 FILL: s_last=1 with counter!=FRAME_N-1, or accepted pixel at counter==FRAME_N-1 without s_last, SHALL set o_err[0], go IDLE; engine not launched.
REQ-013 LAUNCH: when i_eng_idle=1 SHALL assert o_en for exactly one cycle and go PROC; otherwise hold with o_en=0.
REQ-014 o_run SHALL equal mode register and o_num_cnt SHALL equal FRAME_N whenever o_busy=1; both 0 in IDLE.
REQ-015 PROC: i_eng_done=1 SHALL go DONE; i_eng_done outside PROC SHALL be ignored.
REQ-016 DONE: o_frame_done=1 one cycle, o_frame_cnt increments (wraps 16'hFFFF->0), next state IDLE.
REQ-017 s_ready, b0_ce0, b0_we0 SHALL be 0 outside FILL; b0_addr0/b0_d0 SHALL be 0 when b0_we0=0.
REQ-018 o_err bits SHALL be sticky, cleared only by reset or i_start accepted in IDLE.
REQ-019 Launch-to-first-engine-cycle latency SHALL be 1 clock (o_en sampled by engine IDLE).

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, counters 0, mode 0, o_err 0, all outputs 0.
REQ-021 Reset mid-FILL or mid-PROC SHALL abandon frame without o_frame_done; no restart after release.

Configuration
REQ-022 Macro SOBEL_SCHED_TIMEOUT_EN defined: watchdog counts PROC cycles; reaching TIMEOUT_CYCLES without i_eng_done SHALL set o_err[1] and go IDLE, no o_frame_done.
REQ-023 Macro undefined: no watchdog logic; PROC waits indefinitely; o_err[1] tied 0.

Verification
REQ-024 i_start, mode=1, 25 pixels 0..24 with s_last on 25th -> BRAM0 addr 0..24 written, one o_en pulse, o_run=1, o_num_cnt=25.
REQ-025 i_eng_idle=0 for 10 cycles after fill -> o_en held low 10 cycles, pulses on first idle cycle.
REQ-026 i_eng_done pulse in PROC -> o_frame_done next cycle, o_frame_cnt 0->1, o_busy falls.
REQ-027 s_last on 10th pixel -> o_err=2'b01, state IDLE, no o_en.
REQ-028 SOBEL_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, no i_eng_done -> o_err=2'b10 after 16 PROC cycles.
REQ-029 rst_n low during FILL pixel 12 -> all outputs 0 immediately, o_frame_cnt=0.
